// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: merges in-order pipeline writebacks with a
// small FIFO of long-latency results, tracks pending long-latency
// destinations in a busy scoreboard and forces the FIFO through after it
// has lost arbitration STARVE_LIMIT times in a row.
// Optional feature: define WB_BYPASS_EN to forward the registered write
// port to the decode read addresses (and mask the busy bits on a hit).
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_wr_reg,
  input  logic [31:0] pipe_wr_data,
  output logic        pipe_stall,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_reg,
  input  logic [31:0] mc_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        busy1,
  output logic        busy2,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data2,
  output logic        sb_conflict,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_reg  [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   busy;
  logic [31:0]   busy_next;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          pipe_req;
  logic          pipe_win;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign head_reg  = fifo_reg[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // A write to r0 is architecturally meaningless, so it is not a request.
  assign pipe_req   = pipe_wr_en && (pipe_wr_reg != 5'd0);
  assign pipe_stall = !reset && !empty && (starve_cnt == CW'(STARVE_LIMIT));
  assign pipe_win   = pipe_req && !pipe_stall;
  assign pop        = !empty && !pipe_win;
  assign mc_ready   = !reset && !full;
  assign push       = mc_valid && mc_ready;

  // Long-latency result FIFO storage and circular pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_reg[i]  <= '0;
        fifo_data[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_reg[wr_ptr]  <= mc_reg;
        fifo_data[wr_ptr] <= mc_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port: pipeline wins unless stalled, else FIFO head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else if (pipe_win) begin
      RegWrite       <= 1'b1;
      Write_register <= pipe_wr_reg;
      Write_data     <= pipe_wr_data;
    end else if (pop) begin
      RegWrite       <= (head_reg != 5'd0);
      Write_register <= head_reg;
      Write_data     <= head_data;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Counts consecutive losses of a non-empty FIFO to the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pop || empty) begin
      starve_cnt <= '0;
    end else if (pipe_win) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Next busy vector: a pop clears its register, a new issue sets (and wins).
  always_comb begin
    busy_next = busy;
    if (pop) begin
      busy_next[head_reg] = 1'b0;
    end
    if (issue_valid && (issue_reg != 5'd0)) begin
      busy_next[issue_reg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register and sticky double-issue flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      sb_conflict <= 1'b0;
    end else begin
      busy <= busy_next;
      if (issue_valid && (issue_reg != 5'd0) && busy[issue_reg]) begin
        sb_conflict <= 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the registered write port and hide busy bits it satisfies.
  always_comb begin
    fwd_hit1  = RegWrite && (Write_register == chk_reg1) && (chk_reg1 != 5'd0);
    fwd_hit2  = RegWrite && (Write_register == chk_reg2) && (chk_reg2 != 5'd0);
    fwd_data1 = Write_data;
    fwd_data2 = Write_data;
    busy1     = busy[chk_reg1] && !fwd_hit1;
    busy2     = busy[chk_reg2] && !fwd_hit2;
  end
`else
  // No forwarding path: busy bits are reported as stored.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    busy1     = busy[chk_reg1];
    busy2     = busy[chk_reg2];
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a queue-based reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_regfile_write_arbiter;

  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_reg;
  logic [31:0] pipe_wr_data;
  logic        pipe_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_reg;
  logic [31:0] mc_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        busy1;
  logic        busy2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic        sb_conflict;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_wr_en    (pipe_wr_en),
    .pipe_wr_reg   (pipe_wr_reg),
    .pipe_wr_data  (pipe_wr_data),
    .pipe_stall    (pipe_stall),
    .mc_valid      (mc_valid),
    .mc_ready      (mc_ready),
    .mc_reg        (mc_reg),
    .mc_data       (mc_data),
    .issue_valid   (issue_valid),
    .issue_reg     (issue_reg),
    .chk_reg1      (chk_reg1),
    .chk_reg2      (chk_reg2),
    .busy1         (busy1),
    .busy2         (busy2),
    .fwd_hit1      (fwd_hit1),
    .fwd_data1     (fwd_data1),
    .fwd_hit2      (fwd_hit2),
    .fwd_data2     (fwd_data2),
    .sb_conflict   (sb_conflict),
    .RegWrite      (RegWrite),
    .Write_register(Write_register),
    .Write_data    (Write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } entry_t;

  entry_t      mq[$];
  logic        m_rw      = 1'b0;
  logic [4:0]  m_wreg    = '0;
  logic [31:0] m_wdata   = '0;
  int          m_starve  = 0;
  logic [31:0] m_busy    = '0;
  logic        m_conflict = 1'b0;

  function automatic logic model_ready();
    return !reset && (mq.size() < FIFO_DEPTH);
  endfunction

  function automatic logic model_stall();
    return !reset && (mq.size() > 0) && (m_starve == STARVE_LIMIT);
  endfunction

  function automatic logic model_hit(input logic [4:0] c);
`ifdef WB_BYPASS_EN
    return m_rw && (m_wreg == c) && (c != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock edge, or clear it on reset.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_rw       = 1'b0;
      m_wreg     = '0;
      m_wdata    = '0;
      m_starve   = 0;
      m_busy     = '0;
      m_conflict = 1'b0;
    end else begin
      automatic logic   preq   = pipe_wr_en && (pipe_wr_reg != 5'd0);
      automatic logic   pwin   = preq && !model_stall();
      automatic logic   dopop  = (mq.size() > 0) && !pwin;
      automatic logic   dopush = mc_valid && model_ready();
      automatic logic   was_empty = (mq.size() == 0);
      automatic entry_t head;
      if (pwin) begin
        m_rw = 1'b1; m_wreg = pipe_wr_reg; m_wdata = pipe_wr_data;
      end else if (dopop) begin
        head = mq.pop_front();
        m_rw = (head.r != 5'd0); m_wreg = head.r; m_wdata = head.d;
      end else begin
        m_rw = 1'b0;
      end
      if (dopop || was_empty) m_starve = 0;
      else m_starve = m_starve + 1;
      if (issue_valid && issue_reg != 5'd0 && m_busy[issue_reg]) m_conflict = 1'b1;
      if (dopop) m_busy[head.r] = 1'b0;
      if (issue_valid && issue_reg != 5'd0) m_busy[issue_reg] = 1'b1;
      m_busy[0] = 1'b0;
      if (dopush) mq.push_back('{r: mc_reg, d: mc_data});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model shortly after each edge.
  initial forever begin
    @(posedge clk);
    #2;
    checkOutput("cmp_RegWrite", 32'(RegWrite), 32'(m_rw));
    if (m_rw) begin
      checkOutput("cmp_Write_register", 32'(Write_register), 32'(m_wreg));
      checkOutput("cmp_Write_data", Write_data, m_wdata);
    end
    checkOutput("cmp_pipe_stall", 32'(pipe_stall), 32'(model_stall()));
    checkOutput("cmp_mc_ready", 32'(mc_ready), 32'(model_ready()));
    checkOutput("cmp_sb_conflict", 32'(sb_conflict), 32'(m_conflict));
    checkOutput("cmp_busy1", 32'(busy1), 32'(m_busy[chk_reg1] && !model_hit(chk_reg1)));
    checkOutput("cmp_busy2", 32'(busy2), 32'(m_busy[chk_reg2] && !model_hit(chk_reg2)));
    checkOutput("cmp_fwd_hit1", 32'(fwd_hit1), 32'(model_hit(chk_reg1)));
    checkOutput("cmp_fwd_hit2", 32'(fwd_hit2), 32'(model_hit(chk_reg2)));
`ifdef WB_BYPASS_EN
    checkOutput("cmp_fwd_data1", fwd_data1, m_wdata);
    checkOutput("cmp_fwd_data2", fwd_data2, m_wdata);
`else
    checkOutput("cmp_fwd_data1", fwd_data1, 32'd0);
    checkOutput("cmp_fwd_data2", fwd_data2, 32'd0);
`endif
  end

  // Drive one cycle of inputs at a falling edge and wait for the next one.
  task automatic applyStimulus(input logic pwe, input logic [4:0] preg, input logic [31:0] pdata,
                               input logic mv, input logic [4:0] mreg, input logic [31:0] mdata,
                               input logic iv, input logic [4:0] ireg,
                               input logic [4:0] c1, input logic [4:0] c2);
    pipe_wr_en = pwe; pipe_wr_reg = preg; pipe_wr_data = pdata;
    mc_valid = mv; mc_reg = mreg; mc_data = mdata;
    issue_valid = iv; issue_reg = ireg;
    chk_reg1 = c1; chk_reg2 = c2;
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, c1, c2);
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    int pk;
    int mi;
    logic st;
    logic rd;
    reset = 1'b0;
    pipe_wr_en = 1'b0; pipe_wr_reg = '0; pipe_wr_data = '0;
    mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
    issue_valid = 1'b0; issue_reg = '0; chk_reg1 = '0; chk_reg2 = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("rst_mc_ready", 32'(mc_ready), 32'd0);
    checkOutput("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    reset = 1'b0;
    #1 checkOutput("rel_mc_ready", 32'(mc_ready), 32'd1);

    // Plain pipeline writes, including r0.
    applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("p5_RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("p5_reg", 32'(Write_register), 32'd5);
    checkOutput("p5_data", Write_data, 32'h1234_5678);
    applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("p0_RegWrite", 32'(RegWrite), 32'd0);

    // Long-latency result for r9 with the pipeline idle.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    checkOutput("r9_busy_set", 32'(busy1), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 5'd0, 5'd9, 5'd0);
    checkOutput("r9_push_no_write", 32'(RegWrite), 32'd0);
    checkOutput("r9_busy_held", 32'(busy1), 32'd1);
    idle(5'd9, 5'd0);
    checkOutput("r9_pop_RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("r9_pop_reg", 32'(Write_register), 32'd9);
    checkOutput("r9_pop_data", Write_data, 32'hCAFE_F00D);
    checkOutput("r9_busy_clear", 32'(busy1), 32'd0);

    // Double issue to r3, then a pipeline write to the busy register.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    checkOutput("r3_first_conflict", 32'(sb_conflict), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    checkOutput("r3_second_conflict", 32'(sb_conflict), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    checkOutput("r3_pipe_write", 32'(Write_register), 32'd3);
    idle(5'd3, 5'd0);
    checkOutput("r3_busy_kept", 32'(busy1), 32'd1);
    checkOutput("r3_conflict_sticky", 32'(sb_conflict), 32'd1);

    // Fill the FIFO while the pipeline writes every cycle; watch starvation.
    pk = 0;
    mi = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      st = model_stall();
      rd = model_ready();
      applyStimulus(1'b1, 5'(16 + pk % 8), 32'h1000_0000 + 32'(pk),
                    mi < 5, 5'(10 + mi), 32'hB000_0000 + 32'(mi),
                    cyc <= 5, 5'(9 + cyc), 5'd12, 5'd14);
      if (!st) pk++;
      if (mi < 5 && rd) mi++;
      case (cyc)
        4:  checkOutput("full_mc_ready", 32'(mc_ready), 32'd0);
        8:  checkOutput("stall_not_yet", 32'(pipe_stall), 32'd0);
        9:  checkOutput("stall_after_8", 32'(pipe_stall), 32'd1);
        10: begin
          checkOutput("forced_pop_reg", 32'(Write_register), 32'd10);
          checkOutput("forced_pop_data", Write_data, 32'hB000_0000);
          checkOutput("stall_one_cycle", 32'(pipe_stall), 32'd0);
        end
        11: begin
          checkOutput("held_pipe_reg", 32'(Write_register), 32'd17);
          checkOutput("held_pipe_data", Write_data, 32'h1000_0009);
        end
        18: checkOutput("stall_again", 32'(pipe_stall), 32'd1);
        19: checkOutput("second_pop_reg", 32'(Write_register), 32'd11);
        27: checkOutput("r12_busy_before_pop", 32'(busy1), 32'd1);
        28: begin
          checkOutput("third_pop_reg", 32'(Write_register), 32'd12);
          checkOutput("r12_busy_after_pop", 32'(busy1), 32'd0);
        end
        default: ;
      endcase
    end
    repeat (6) idle(5'd13, 5'd14);
    checkOutput("drain_busy_r14", 32'(busy2), 32'd0);
    checkOutput("drain_mc_ready", 32'(mc_ready), 32'd1);

    // Reset with three results buffered.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd1, 32'h0000_1111, 1'b1, 5'(20 + i), 32'hC000_0000 + 32'(i),
                    1'b1, 5'(20 + i), 5'd20, 5'd22);
    end
    checkOutput("pre_reset_busy", 32'(busy1), 32'd1);
    pipe_wr_en = 1'b0; mc_valid = 1'b0; issue_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("arst_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("arst_Write_register", 32'(Write_register), 32'd0);
    checkOutput("arst_Write_data", Write_data, 32'd0);
    checkOutput("arst_mc_ready", 32'(mc_ready), 32'd0);
    checkOutput("arst_busy1", 32'(busy1), 32'd0);
    checkOutput("arst_conflict", 32'(sb_conflict), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(5'd20, 5'd22);
      checkOutput("post_reset_no_write", 32'(RegWrite), 32'd0);
    end
    checkOutput("post_reset_ready", 32'(mc_ready), 32'd1);

    // Set wins over a same-edge clear; a popped r0 entry writes nothing.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 5'd5, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
    checkOutput("r5_pop_reg", 32'(Write_register), 32'd5);
    checkOutput("r5_reissue_conflict", 32'(sb_conflict), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_0077, 1'b0, 5'd0, 5'd5, 5'd0);
    checkOutput("r5_set_wins", 32'(busy1), 32'd1);
    idle(5'd5, 5'd0);
    checkOutput("r0_pop_no_write", 32'(RegWrite), 32'd0);

    // Forwarding path for r7.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd5);
    applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd5);
`ifdef WB_BYPASS_EN
    checkOutput("byp_fwd_hit1", 32'(fwd_hit1), 32'd1);
    checkOutput("byp_fwd_data1", fwd_data1, 32'hA5A5_A5A5);
    checkOutput("byp_busy1_masked", 32'(busy1), 32'd0);
`else
    checkOutput("nobyp_fwd_hit1", 32'(fwd_hit1), 32'd0);
    checkOutput("nobyp_fwd_data1", fwd_data1, 32'd0);
    checkOutput("nobyp_busy1", 32'(busy1), 32'd1);
`endif
    checkOutput("byp_busy2_r5", 32'(busy2), 32'd1);
    repeat (2) idle(5'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
